seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, sitting directly downstream of `Control` and producing the `seven_segment`/`enable` pins it exports.

- Accepts a 16-bit hex value plus a per-digit blank mask through a load strobe.
- Double-buffers the value and commits it only at frame boundaries, so a digit never tears mid-scan.
- Scans one digit at a time, with a one-cycle all-off gap between digits to suppress ghosting.

---
 rtl/seven_seg_scanner_pkg.sv | 38 +++
 rtl/seven_seg_scanner_hex_to_seg.sv | 13 +
 rtl/seven_seg_scanner.sv | 128 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment display code.
//   SEG_OFF / EN_OFF : all-dark segment and anode patterns (active-low)
//   scan_state_e     : scanner states ST_GAP / ST_DRIVE
//   hex2seg()        : 4-bit hex digit to active-low {g,f,e,d,c,b,a}
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] EN_OFF  = 4'b1111;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex digit decoder.
//   hex_i : 4-bit digit value
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A loaded value waits in a pending buffer and is committed only at the end
// of a full scan, so no digit ever shows a half-updated frame. Each digit is
// driven for CLK_DIV cycles, preceded by a one-cycle all-dark gap.
//   clk           : system clock, rising edge
//   reset_btn     : asynchronous reset, active-low
//   value         : 16-bit hex value, value[3:0] is digit 0 (rightmost)
//   blank         : blank[i]=1 keeps digit i dark
//   load          : one-cycle strobe capturing value/blank into pending
//   seven_segment : active-low segments {g,f,e,d,c,b,a}
//   enable        : active-low digit anodes, enable[i] selects digit i
//   frame_done    : one-cycle pulse during the gap that follows each frame
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_btn,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  seven_segment,
  output logic [3:0]  enable,
  output logic        frame_done
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  scan_state_e      state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      shown_val_q;
  logic [3:0]       shown_blank_q;
  logic [15:0]      pend_val_q;
  logic [3:0]       pend_blank_q;
  logic             pend_valid_q;
  logic             boundary_q;
  logic [6:0]       seg_q;
  logic [3:0]       en_q;
  logic             frame_done_q;

  logic [3:0]       cur_hex;
  logic [6:0]       cur_seg;
  logic             last_cycle;
  logic             boundary;

  assign cur_hex    = shown_val_q[{idx_q, 2'b00} +: 4];
  assign last_cycle = (state_q == ST_DRIVE) && (cnt_q == CNT_LAST);
  assign boundary   = last_cycle && (idx_q == 2'd3);

  hex_to_seg u_hex_to_seg (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // The pin registers are loaded from the current state, so the visible
  // pattern trails the state by one cycle: after reset the first edge shows
  // the gap and the second edge shows digit 0.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q       <= ST_GAP;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      shown_val_q   <= 16'h0000;
      shown_blank_q <= 4'b0000;
      pend_valid_q  <= 1'b0;
      boundary_q    <= 1'b0;
      seg_q         <= SEG_OFF;
      en_q          <= EN_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      // boundary_q is high exactly while the post-frame gap is the state,
      // which is the cycle its all-dark pattern reaches the pins.
      boundary_q   <= boundary;
      frame_done_q <= boundary_q;

      if ((state_q == ST_DRIVE) && !shown_blank_q[idx_q]) begin
        en_q  <= ~(4'b0001 << idx_q);
        seg_q <= cur_seg;
      end else begin
        en_q  <= EN_OFF;
        seg_q <= SEG_OFF;
      end

      case (state_q)
        ST_GAP: begin
          state_q <= ST_DRIVE;
          cnt_q   <= '0;
        end
        ST_DRIVE: begin
          if (last_cycle) begin
            state_q <= ST_GAP;
            idx_q   <= idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase

      // Commit takes the pending contents as they were before this edge;
      // a load on the same edge refills pending for the next frame.
      if (boundary && pend_valid_q) begin
        shown_val_q   <= pend_val_q;
        shown_blank_q <= pend_blank_q;
      end
      if (load) begin
        pend_valid_q <= 1'b1;
      end else if (boundary) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Pending payload is qualified by pend_valid_q and needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_val_q   <= value;
      pend_blank_q <= blank;
    end
  end

  assign seven_segment = seg_q;
  assign enable        = en_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with CLK_DIV=4 (20-cycle frame).
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset_btn = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  blank = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seven_segment;
  logic [3:0]  enable;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  seven_seg_scanner #(.CLK_DIV(4)) dut (
    .clk           (clk),
    .reset_btn     (reset_btn),
    .value         (value),
    .blank         (blank),
    .load          (load),
    .seven_segment (seven_segment),
    .enable        (enable),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference: k counts edges since reset release. The pins after edge k sit
  // at frame position p=(k-1)%20: p=0 is the inter-frame gap (frame_done
  // except for the very first one), otherwise slot (p-1)/5 with 4 drive
  // cycles followed by a 1-cycle gap. Commits happen on edges k=20,40,...
  int          k = 0;
  logic [15:0] m_shown = 16'h0, m_pend = 16'h0;
  logic [3:0]  m_sblank = 4'h0, m_pblank = 4'h0;
  bit          m_pv = 1'b0;
  logic [6:0]  e_seg = 7'h7f;
  logic [3:0]  e_en = 4'hf;
  logic        e_fd = 1'b0;

  always @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      k <= 0; m_shown <= 16'h0; m_sblank <= 4'h0; m_pv <= 1'b0;
      e_seg <= 7'h7f; e_en <= 4'hf; e_fd <= 1'b0;
    end else begin : mstep
      int kn, p, s, r;
      logic [6:0] sg;
      logic [3:0] en;
      kn = k + 1;
      p  = (kn - 1) % 20;
      sg = 7'h7f; en = 4'hf;
      if (p != 0) begin
        s = (p - 1) / 5;
        r = (p - 1) % 5;
        if (r < 4 && !m_sblank[s]) begin
          en[s] = 1'b0;
          sg = segtab[m_shown[4*s +: 4]];
        end
      end
      k     <= kn;
      e_seg <= sg;
      e_en  <= en;
      e_fd  <= (p == 0) && (kn > 1);
      if (kn % 20 == 0 && m_pv) begin
        m_shown <= m_pend; m_sblank <= m_pblank; m_pv <= 1'b0;
      end
      if (load) begin
        m_pend <= value; m_pblank <= blank; m_pv <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (enable !== e_en || seven_segment !== e_seg || frame_done !== e_fd) begin
        errors++;
        $display("FAIL model k=%0d: enable=%b seg=%b fd=%b required enable=%b seg=%b fd=%b",
                 k, enable, seven_segment, frame_done, e_en, e_seg, e_fd);
      end
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [3:0] en, input logic [6:0] sg, input logic fd);
    checks++;
    if (enable !== en || seven_segment !== sg || frame_done !== fd) begin
      errors++;
      $display("FAIL %s: enable=%b seg=%b fd=%b required enable=%b seg=%b fd=%b",
               nm, enable, seven_segment, frame_done, en, sg, fd);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_fd: frame_done=%b required 1 within 60 cycles", frame_done);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b);
    value = v; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0; blank = 4'h0;
  endtask

  logic [3:0] bas_en [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] bas_sg [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};

  initial begin
    // Reset held
    @(posedge clk);
    chk_on = 1'b1;
    skip(3);
    lit("reset_hold", 4'b1111, 7'b1111111, 1'b0);
    reset_btn = 1'b1;
    skip(1);
    lit("first_gap", 4'b1111, 7'b1111111, 1'b0);
    skip(1);
    lit("dig0_first", 4'b1110, 7'b1000000, 1'b0);
    skip(3);
    lit("dig0_last", 4'b1110, 7'b1000000, 1'b0);
    skip(1);
    lit("gap_after_dig0", 4'b1111, 7'b1111111, 1'b0);

    // Basic load of 1A3F
    do_load(16'h1A3F, 4'h0);
    wait_fd();
    for (int p = 1; p < 20; p++) begin
      skip(1);
      if ((p - 1) % 5 < 4)
        lit("basic_digit", bas_en[(p - 1) / 5], bas_sg[(p - 1) / 5], 1'b0);
      else
        lit("basic_gap", 4'b1111, 7'b1111111, 1'b0);
    end

    // Mid-frame load during digit 1
    wait_fd();
    skip(6);
    lit("mid_d1_old", 4'b1101, 7'b0110000, 1'b0);
    do_load(16'h0002, 4'h0);
    skip(4);
    lit("mid_d2_old", 4'b1011, 7'b0001000, 1'b0);
    skip(5);
    lit("mid_d3_old", 4'b0111, 7'b1111001, 1'b0);
    wait_fd();
    skip(1);
    lit("mid_d0_new", 4'b1110, 7'b0100100, 1'b0);
    skip(5);
    lit("mid_d1_new", 4'b1101, 7'b1000000, 1'b0);

    // Overwrite within a frame: only 5678 shows
    do_load(16'h1234, 4'h0);
    skip(3);
    do_load(16'h5678, 4'h0);
    wait_fd();
    skip(1);
    lit("ovw_d0", 4'b1110, 7'b0000000, 1'b0);
    skip(5);
    lit("ovw_d1", 4'b1101, 7'b1111000, 1'b0);
    skip(5);
    lit("ovw_d2", 4'b1011, 7'b0000010, 1'b0);
    skip(5);
    lit("ovw_d3", 4'b0111, 7'b0010010, 1'b0);

    // Load sampled on the boundary edge lands one frame later
    wait_fd();
    skip(3);
    do_load(16'h00C0, 4'h0);
    skip(14);
    do_load(16'h000D, 4'h0);
    wait_fd();
    skip(1);
    lit("bnd_commit_d0", 4'b1110, 7'b1000000, 1'b0);
    skip(5);
    lit("bnd_commit_d1", 4'b1101, 7'b1000110, 1'b0);
    wait_fd();
    skip(1);
    lit("bnd_next_d0", 4'b1110, 7'b0100001, 1'b0);

    // Blank mask
    do_load(16'h0042, 4'b1100);
    wait_fd();
    skip(1);
    lit("blk_d0", 4'b1110, 7'b0100100, 1'b0);
    skip(5);
    lit("blk_d1", 4'b1101, 7'b0011001, 1'b0);
    skip(5);
    lit("blk_d2", 4'b1111, 7'b1111111, 1'b0);
    skip(5);
    lit("blk_d3", 4'b1111, 7'b1111111, 1'b0);

    // Random loads against the reference
    repeat (400) begin
      @(negedge clk);
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    end
    @(negedge clk);
    load = 1'b0; blank = 4'h0;

    // Async reset mid-drive with a pending load
    wait_fd();
    skip(2);
    do_load(16'hBEEF, 4'h0);
    @(posedge clk);
    #2 reset_btn = 1'b0;
    #1 lit("async_blank", 4'b1111, 7'b1111111, 1'b0);
    skip(3);
    reset_btn = 1'b1;
    skip(1);
    lit("rst_gap", 4'b1111, 7'b1111111, 1'b0);
    skip(1);
    lit("rst_d0", 4'b1110, 7'b1000000, 1'b0);
    wait_fd();
    skip(1);
    lit("rst_no_pend_d0", 4'b1110, 7'b1000000, 1'b0);
    skip(5);
    lit("rst_no_pend_d1", 4'b1101, 7'b1000000, 1'b0);

    skip(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
